uart_tx: RTL



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_if.sv | 26 ++
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, parity encodings, FSM states and helpers.
package uart_pkg;

    localparam int BASE_CLK_DEFAULT = 50_000_000;
    localparam int BAUDRATE_DEFAULT = 115_200;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per serial bit, truncated (50 MHz / 115200 -> 434).
    function automatic int clks_per_bit(input int base_clk, input int baudrate);
        return base_clk / baudrate;
    endfunction

    // Encoding 3 is reserved and behaves like "no parity".
    function automatic logic parity_enabled(input logic [1:0] parity_type);
        return (parity_type == PARITY_ODD) || (parity_type == PARITY_EVEN);
    endfunction

    // Parity bit so that data plus parity has an odd (ODD) or even (EVEN) ones count.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] parity_type);
        return (parity_type == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter request/status bundle.
// Handshake: tx_start is the valid strobe and ~tx_busy is ready; a frame is
// accepted on the rising edge where tx_start=1 and tx_busy=0, and tx_data /
// parity_type are sampled on that edge only. tx_start while busy is dropped.
interface uart_tx_if;
    import uart_pkg::*;

    logic [7:0]  tx_data;
    logic        tx_start;
    logic [1:0]  parity_type;
    logic        serial_data_out;
    logic        tx_busy;
    logic        tx_done;
    uart_state_t state;       // current FSM state, for observation

    modport master (
        output tx_data, tx_start, parity_type,
        input  serial_data_out, tx_busy, tx_done, state
    );

    modport slave (
        input  tx_data, tx_start, parity_type,
        output serial_data_out, tx_busy, tx_done, state
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_tick = en && (cnt_q == LAST);

    // Count cycles within the current bit; wrap to 0 on each bit advance.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= bit_tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BASE_CLK = BASE_CLK_DEFAULT,
    parameter int BAUDRATE = BAUDRATE_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    uart_tx_if.slave  bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(BASE_CLK, BAUDRATE);

    uart_state_t state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q;
    logic [1:0]  par_q;
    logic        line_q, busy_q, done_q;
    logic        line_d, busy_d, done_d;
    logic        accept;
    logic        bit_tick;

    assign accept = (state_q == IDLE) && bus.tx_start;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .en       (state_q != IDLE),
        .bit_tick (bit_tick)
    );

    // State, bit index, latched frame contents and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_q     <= PARITY_NONE;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (accept) begin
                data_q <= bus.tx_data;
                par_q  <= bus.parity_type;
            end
        end
    end

    // Next state: advance one bit per bit_tick, parity only when enabled.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (bus.tx_start) state_d = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = parity_enabled(par_q) ? PARITY : STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the flops present them in step with it.
    always_comb begin
        line_d = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && bit_tick;
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = data_q[bit_idx_d];
            PARITY:  line_d = parity_bit(data_q, par_q);
            default: line_d = 1'b1;
        endcase
    end

    assign bus.serial_data_out = line_q;
    assign bus.tx_busy         = busy_q;
    assign bus.tx_done         = done_q;
    assign bus.state           = state_q;

endmodule
